// File: rtl/conv_result_collector_pkg.sv
// Shared definitions for the convolution result collector: FSM encoding,
// frame-size and packing helpers, and the default packed word width.
package conv_pkg;

  localparam int WORD_BITS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Number of valid convolution outputs for a square image and kernel.
  function automatic int out_pix(input int img_length, input int kernel_size);
    return (img_length - kernel_size + 1) * (img_length - kernel_size + 1);
  endfunction

  // Number of whole pixels that fit into one packed word.
  function automatic int ppw(input int word_bits, input int bits);
    return word_bits / bits;
  endfunction

endpackage

// File: rtl/conv_result_collector_if.sv
// Stream-side and host-side handshake signals of the result collector.
// The master drives pixels and the host ready; the slave is the collector.
interface conv_result_collector_if
  import conv_pkg::*;
#(
  parameter int BITS      = 9,
  parameter int WORD_BITS = WORD_BITS_DEF
) ();

  logic                 frame_start;
  logic                 in_valid;
  logic [BITS-1:0]      in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_BITS-1:0] out_data;

  modport master (
    output frame_start, in_valid, in_pixel, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  frame_start, in_valid, in_pixel, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/conv_result_collector_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible whenever the FIFO
// is non-empty; a pop in the same cycle frees a slot for a push even when full.
module conv_sync_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH = WORD_BITS_DEF,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags, effective push/pop and the show-ahead head word.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush and reset both return to the empty state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects convolution output pixels, packs them LSB-first into words,
// buffers the words for the host and reports frame completion and overflow.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 16,
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int FIFO_DEPTH  = 16,
  localparam int OUT_PIX    = out_pix(IMG_LENGTH, KERNEL_SIZE),
  localparam int PPW        = ppw(WORD_BITS, BITS),
  localparam int CNT_W      = $clog2(OUT_PIX + 1),
  localparam int LANE_W     = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_result_collector_if.slave bus,
  output logic [CNT_W-1:0]       pixel_count,
  output logic                   frame_done,
  output logic                   overflow
);

  state_t               state;
  state_t               next_state;
  logic                 start;
  logic                 restart;
  logic                 accept;
  logic [LANE_W-1:0]    lane_idx;
  logic [PPW*BITS-1:0]  pack_bits;
  logic [PPW*BITS-1:0]  next_pack;
  logic [WORD_BITS-1:0] packed_word;
  logic                 word_complete;
  logic                 push_pending;
  logic [WORD_BITS-1:0] push_word;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop_req;
  logic                 drop;
  logic [WORD_BITS-1:0] fifo_head;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state and per-cycle control; DONE is entered on the edge that pushes the last word.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    restart    = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          start      = 1'b1;
          next_state = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.frame_start) begin
          start   = 1'b1;
          restart = 1'b1;
        end else begin
          accept = bus.in_valid && (pixel_count < CNT_W'(OUT_PIX));
          if (push_pending && (pixel_count == CNT_W'(OUT_PIX))) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        if (bus.frame_start) begin
          start      = 1'b1;
          next_state = ST_COLLECT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Packer lane insertion and word completion (full word or last pixel of the frame).
  always_comb begin
    next_pack = pack_bits;
    next_pack[lane_idx*BITS +: BITS] = bus.in_pixel;
    packed_word = '0;
    packed_word[PPW*BITS-1:0] = next_pack;
    word_complete = (lane_idx == LANE_W'(PPW - 1)) || (pixel_count == CNT_W'(OUT_PIX - 1));
  end

  // FIFO handshake and overflow detection; a restart cancels any pending push.
  always_comb begin
    pop_req   = bus.out_ready && !fifo_empty;
    fifo_push = push_pending && !restart;
    drop      = fifo_push && fifo_full && !pop_req;
  end

  // Pixel counter, packer, pending-word register and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_count  <= '0;
      lane_idx     <= '0;
      pack_bits    <= '0;
      push_pending <= 1'b0;
      push_word    <= '0;
      overflow     <= 1'b0;
    end else begin
      push_pending <= 1'b0;
      if (start) begin
        pixel_count <= '0;
        lane_idx    <= '0;
        pack_bits   <= '0;
      end else if (accept) begin
        pixel_count <= pixel_count + CNT_W'(1);
        if (word_complete) begin
          push_pending <= 1'b1;
          push_word    <= packed_word;
          pack_bits    <= '0;
          lane_idx     <= '0;
        end else begin
          pack_bits <= next_pack;
          lane_idx  <= lane_idx + LANE_W'(1);
        end
      end
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  conv_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (bus.out_ready),
    .flush     (restart),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;

endmodule
